rf_hazard_ctrl: RTL and testbench
=================================

RF_HAZARD_CTRL -- requirements
Module: rf_hazard_ctrl

Interface
REQ-001 SHALL have ports `clk` (in, 1, clock) and `reset` (in, 1, reset): synchronous, active-high.
REQ-002 SHALL have ID-side inputs `id_valid` (1), `id_rs1` (5), `id_rs1_use` (1), `id_rs2` (5), `id_rs2_use` (1), `id_dest` (5), `id_gr_we` (1) and `id_is_load` (1), describing the instruction in ID.
REQ-003 SHALL have pipeline-move inputs, each 1 bit: `id_to_ex_fire`, `ex_to_mem_fire`, `mem_to_wb_fire`, `wb_retire`.
REQ-004 SHALL have `id_stall` (out, 1): ID must not advance.
REQ-005 SHALL have `fwd_sel1` and `fwd_sel2` (out, 2 each): source for rs1/rs2; 0 = regfile, 1 = EX, 2 = MEM, 3 = WB.
REQ-006 SHALL have `busy_vec` (out, 32): bit n set when any tracked slot writes register n.
REQ-007 SHALL have `scb_err` (out, 1): sticky protocol-error flag.

Function
REQ-008 SHALL hold three shadow slots (EX, MEM, WB), each holding {valid, dest[4:0], we, is_load}.
REQ-009 On `id_to_ex_fire`, the EX slot SHALL load {1, id_dest, id_gr_we && id_dest!=0, id_is_load}.
REQ-010 On `ex_to_mem_fire` and `mem_to_wb_fire`, contents SHALL shift EX->MEM and MEM->WB; a vacated slot not refilled the same cycle SHALL clear `valid`.
REQ-011 On `wb_retire`, the WB slot SHALL clear `valid` unless `mem_to_wb_fire` refills it the same cycle.
REQ-012 All four moves in one cycle SHALL update simultaneously, using old slot contents as the sources.
REQ-013 A slot SHALL match source rs when valid && we && dest==rs && rs!=0 && the matching `*_use` is set.
REQ-014 Without forwarding, `id_stall` SHALL be `id_valid` && (any slot matches rs1 or rs2), purely combinational.
REQ-015 `fwd_sel*` SHALL select the youngest matching slot (EX > MEM > WB), or 0 if none matches; the output is meaningful only with forwarding enabled.
REQ-016 Register 0 SHALL never be marked busy, stall or forward.
REQ-017 `busy_vec` SHALL be combinational from the slots.
REQ-018 `scb_err` SHALL set, and stay set until reset, on:
- `ex_to_mem_fire` with EX empty;
- `mem_to_wb_fire` with MEM empty;
- `wb_retire` with WB empty;
- `mem_to_wb_fire` with WB valid and no `wb_retire`;
- `id_to_ex_fire` while `id_stall`.
REQ-019 On any protocol error, slot update SHALL proceed as specified anyway; no blocking.

Reset
REQ-020 While `reset` is high at a clk edge, all slots SHALL be cleared and `scb_err` SHALL be 0; fire inputs that cycle SHALL be ignored.
REQ-021 After reset, `id_stall`=0, `fwd_sel1`=`fwd_sel2`=0 and `busy_vec`=0 SHALL hold regardless of ID inputs.
REQ-022 Reset asserted mid-operation SHALL discard all in-flight tracking in one cycle.

Configuration
REQ-023 Macro `RF_HAZARD_FWD_EN` SHALL select the forwarding behaviour.
REQ-024 With `RF_HAZARD_FWD_EN` defined, `id_stall` SHALL assert only on load-use: EX slot matches with is_load=1; MEM and WB matches forward without stall.
REQ-025 With `RF_HAZARD_FWD_EN` undefined, REQ-014 applies and `fwd_sel*` SHALL be tied to 0.

Structure
REQ-026 The `fwd_sel` encodings (FWD_RF, FWD_EX, FWD_MEM, FWD_WB) and the slot field width SHALL live in shared `constants.h`.
REQ-027 One sub-module, `hazard_slot` (single slot register with load/clear/hold), SHALL be instantiated three times.
REQ-028 Match and priority logic SHALL stay in `rf_hazard_ctrl`.

Verification
REQ-029 Reset, then id rs1=5 used, no fires -> `id_stall`=0, `busy_vec`=0, `fwd_sel1`=0.
REQ-030 Without FWD: issue dest=5, we=1; next cycle ID rs1=5 -> `id_stall`=1 through EX, MEM and WB; deasserts the cycle after `wb_retire`.
REQ-031 With FWD: issue load dest=7; ID rs2=7 -> `id_stall`=1; after `ex_to_mem_fire`, `id_stall`=0 and `fwd_sel2`=2.
REQ-032 Slots EX dest=3, MEM dest=3, WB dest=3, all we=1; ID rs1=3 -> `fwd_sel1`=1 (youngest wins); issue dest=0, we=1 -> `busy_vec`=0.
REQ-033 All four fires in one cycle with full slots -> slots shift exactly one stage, no loss, `scb_err`=0.
REQ-034 `wb_retire` with WB empty -> `scb_err`=1 and held until `reset`; assert `reset` with full slots -> next cycle all outputs 0.

Source files
------------

// File: rtl/rf_hazard_ctrl_pkg.sv
// Shared definitions for the register-file hazard scoreboard: forwarding-source
// encodings, the per-stage slot record, and the slot/source match helper.
package rf_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_e;

  localparam int unsigned SLOT_W = 8;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       we;
    logic       is_load;
  } slot_t;

  // A slot produces a source only if it will write it and the source is really read.
  function automatic logic slot_match(input slot_t s, input logic [4:0] rs,
                                      input logic rs_use);
    return s.valid && s.we && (s.dest == rs) && (rs != 5'd0) && rs_use;
  endfunction

endpackage

// File: rtl/rf_hazard_ctrl_hazard_slot.sv
// One shadow slot of the hazard scoreboard: load has priority over clear,
// otherwise the slot holds.
module hazard_slot
  import rf_hazard_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load_i,
  input  logic  clear_i,
  input  slot_t din_i,
  output slot_t q_o
);

  slot_t slot_q;
  slot_t slot_d;

  always_comb begin
    slot_d = slot_q;
    if (load_i) begin
      slot_d = din_i;
    end else if (clear_i) begin
      slot_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign q_o = slot_q;

endmodule

// File: rtl/rf_hazard_ctrl.sv
// Register-file hazard scoreboard tracking EX/MEM/WB destinations for the
// instruction in ID. Define RF_HAZARD_FWD_EN to stall only on load-use and forward.
module rf_hazard_ctrl
  import rf_hazard_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic        id_rs1_use,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs2_use,
  input  logic [4:0]  id_dest,
  input  logic        id_gr_we,
  input  logic        id_is_load,
  input  logic        id_to_ex_fire,
  input  logic        ex_to_mem_fire,
  input  logic        mem_to_wb_fire,
  input  logic        wb_retire,
  output logic        id_stall,
  output logic [1:0]  fwd_sel1,
  output logic [1:0]  fwd_sel2,
  output logic [31:0] busy_vec,
  output logic        scb_err
);

  slot_t ex_q;
  slot_t mem_q;
  slot_t wb_q;
  slot_t id_slot;
  slot_t slots [3];

  logic [2:0] m1;
  logic [2:0] m2;
  logic       err_q;
  logic       err_d;

  assign id_slot.valid   = 1'b1;
  assign id_slot.dest    = id_dest;
  assign id_slot.we      = id_gr_we && (id_dest != 5'd0);
  assign id_slot.is_load = id_is_load;

  // Each slot sources from the old contents of the stage before it, so all
  // moves in one cycle behave as a simultaneous shift.
  hazard_slot u_ex (
    .clk     (clk),
    .reset   (reset),
    .load_i  (id_to_ex_fire),
    .clear_i (ex_to_mem_fire),
    .din_i   (id_slot),
    .q_o     (ex_q)
  );

  hazard_slot u_mem (
    .clk     (clk),
    .reset   (reset),
    .load_i  (ex_to_mem_fire),
    .clear_i (mem_to_wb_fire),
    .din_i   (ex_q),
    .q_o     (mem_q)
  );

  hazard_slot u_wb (
    .clk     (clk),
    .reset   (reset),
    .load_i  (mem_to_wb_fire),
    .clear_i (wb_retire),
    .din_i   (mem_q),
    .q_o     (wb_q)
  );

  assign slots[0] = ex_q;
  assign slots[1] = mem_q;
  assign slots[2] = wb_q;

  always_comb begin
    m1 = '0;
    m2 = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      m1[i] = slot_match(slots[i], id_rs1, id_rs1_use);
      m2[i] = slot_match(slots[i], id_rs2, id_rs2_use);
    end
  end

  always_comb begin
    busy_vec = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (slots[i].valid && slots[i].we) begin
        busy_vec[slots[i].dest] = 1'b1;
      end
    end
    busy_vec[0] = 1'b0;
  end

`ifdef RF_HAZARD_FWD_EN
  assign id_stall = id_valid && ex_q.is_load && (m1[0] || m2[0]);

  always_comb begin
    fwd_sel1 = FWD_RF;
    if (m1[0])      fwd_sel1 = FWD_EX;
    else if (m1[1]) fwd_sel1 = FWD_MEM;
    else if (m1[2]) fwd_sel1 = FWD_WB;
  end

  always_comb begin
    fwd_sel2 = FWD_RF;
    if (m2[0])      fwd_sel2 = FWD_EX;
    else if (m2[1]) fwd_sel2 = FWD_MEM;
    else if (m2[2]) fwd_sel2 = FWD_WB;
  end
`else
  assign id_stall = id_valid && ((|m1) || (|m2));
  assign fwd_sel1 = FWD_RF;
  assign fwd_sel2 = FWD_RF;
`endif

  logic unused_is_load;
  assign unused_is_load = ^{ex_q.is_load, wb_q.is_load};

  always_comb begin
    err_d = err_q;
    if ((ex_to_mem_fire && !ex_q.valid) ||
        (mem_to_wb_fire && !mem_q.valid) ||
        (wb_retire && !wb_q.valid) ||
        (mem_to_wb_fire && wb_q.valid && !wb_retire) ||
        (id_to_ex_fire && id_stall)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign scb_err = err_q;

endmodule

// File: tb/tb_rf_hazard_ctrl.sv
// Directed self-checking bench for rf_hazard_ctrl; expectations follow the
// build's RF_HAZARD_FWD_EN setting.
module tb_rf_hazard_ctrl;

`ifdef RF_HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic        id_rs1_use;
  logic [4:0]  id_rs2;
  logic        id_rs2_use;
  logic [4:0]  id_dest;
  logic        id_gr_we;
  logic        id_is_load;
  logic        id_to_ex_fire;
  logic        ex_to_mem_fire;
  logic        mem_to_wb_fire;
  logic        wb_retire;
  logic        id_stall;
  logic [1:0]  fwd_sel1;
  logic [1:0]  fwd_sel2;
  logic [31:0] busy_vec;
  logic        scb_err;

  int checks = 0;
  int failures = 0;

  rf_hazard_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .id_valid       (id_valid),
    .id_rs1         (id_rs1),
    .id_rs1_use     (id_rs1_use),
    .id_rs2         (id_rs2),
    .id_rs2_use     (id_rs2_use),
    .id_dest        (id_dest),
    .id_gr_we       (id_gr_we),
    .id_is_load     (id_is_load),
    .id_to_ex_fire  (id_to_ex_fire),
    .ex_to_mem_fire (ex_to_mem_fire),
    .mem_to_wb_fire (mem_to_wb_fire),
    .wb_retire      (wb_retire),
    .id_stall       (id_stall),
    .fwd_sel1       (fwd_sel1),
    .fwd_sel2       (fwd_sel2),
    .busy_vec       (busy_vec),
    .scb_err        (scb_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    id_to_ex_fire  = 1'b0;
    ex_to_mem_fire = 1'b0;
    mem_to_wb_fire = 1'b0;
    wb_retire      = 1'b0;
  endtask

  task automatic idle_id();
    id_valid   = 1'b0;
    id_rs1     = 5'd0;
    id_rs1_use = 1'b0;
    id_rs2     = 5'd0;
    id_rs2_use = 1'b0;
    id_dest    = 5'd0;
    id_gr_we   = 1'b0;
    id_is_load = 1'b0;
  endtask

  // Sets ID to a non-reading producer; the caller raises the fires it wants.
  task automatic set_issue(input logic [4:0] dest, input logic we, input logic ld);
    idle_id();
    id_valid   = 1'b1;
    id_dest    = dest;
    id_gr_we   = we;
    id_is_load = ld;
    id_to_ex_fire = 1'b1;
  endtask

  task automatic do_reset();
    idle_id();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_id();
    reset = 1'b1;
    id_dest = 5'd9; id_gr_we = 1'b1; id_valid = 1'b1;
    id_to_ex_fire = 1'b1; ex_to_mem_fire = 1'b1;
    tick();
    reset = 1'b0;
    idle_id();
    id_valid = 1'b1; id_rs1 = 5'd5; id_rs1_use = 1'b1;
    #1;
    checks++; if (id_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", id_stall); end
    checks++; if (busy_vec !== 32'h0) begin failures++; $display("FAIL reset_busy got=%h exp=0", busy_vec); end
    checks++; if (fwd_sel1 !== 2'd0) begin failures++; $display("FAIL reset_fwd1 got=%0d exp=0", fwd_sel1); end
    checks++; if (scb_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", scb_err); end
  endtask

  task automatic test_stall_pipeline();
    do_reset();
    set_issue(5'd5, 1'b1, 1'b0);
    tick();
    idle_id();
    id_valid = 1'b1; id_rs1 = 5'd5; id_rs1_use = 1'b1;
    #1;
    checks++; if (busy_vec !== 32'h20) begin failures++; $display("FAIL ex_busy got=%h exp=00000020", busy_vec); end
    checks++; if (id_stall !== !FWD) begin failures++; $display("FAIL ex_stall got=%b exp=%b", id_stall, !FWD); end
    checks++; if (fwd_sel1 !== (FWD ? 2'd1 : 2'd0)) begin failures++; $display("FAIL ex_fwd1 got=%0d exp=%0d", fwd_sel1, FWD ? 1 : 0); end
    ex_to_mem_fire = 1'b1;
    tick();
    checks++; if (id_stall !== !FWD) begin failures++; $display("FAIL mem_stall got=%b exp=%b", id_stall, !FWD); end
    checks++; if (fwd_sel1 !== (FWD ? 2'd2 : 2'd0)) begin failures++; $display("FAIL mem_fwd1 got=%0d exp=%0d", fwd_sel1, FWD ? 2 : 0); end
    mem_to_wb_fire = 1'b1;
    tick();
    checks++; if (id_stall !== !FWD) begin failures++; $display("FAIL wb_stall got=%b exp=%b", id_stall, !FWD); end
    checks++; if (fwd_sel1 !== (FWD ? 2'd3 : 2'd0)) begin failures++; $display("FAIL wb_fwd1 got=%0d exp=%0d", fwd_sel1, FWD ? 3 : 0); end
    wb_retire = 1'b1;
    tick();
    checks++; if (id_stall !== 1'b0) begin failures++; $display("FAIL retire_stall got=%b exp=0", id_stall); end
    checks++; if (busy_vec !== 32'h0) begin failures++; $display("FAIL retire_busy got=%h exp=0", busy_vec); end
    checks++; if (scb_err !== 1'b0) begin failures++; $display("FAIL pipe_err got=%b exp=0", scb_err); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_issue(5'd7, 1'b1, 1'b1);
    tick();
    idle_id();
    id_valid = 1'b1; id_rs2 = 5'd7; id_rs2_use = 1'b1;
    #1;
    checks++; if (id_stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b exp=1", id_stall); end
    ex_to_mem_fire = 1'b1;
    tick();
    checks++; if (id_stall !== !FWD) begin failures++; $display("FAIL lu_mem_stall got=%b exp=%b", id_stall, !FWD); end
    checks++; if (fwd_sel2 !== (FWD ? 2'd2 : 2'd0)) begin failures++; $display("FAIL lu_fwd2 got=%0d exp=%0d", fwd_sel2, FWD ? 2 : 0); end
  endtask

  task automatic test_youngest();
    do_reset();
    set_issue(5'd3, 1'b1, 1'b0);
    tick();
    set_issue(5'd3, 1'b1, 1'b0); ex_to_mem_fire = 1'b1;
    tick();
    set_issue(5'd3, 1'b1, 1'b0); ex_to_mem_fire = 1'b1; mem_to_wb_fire = 1'b1;
    tick();
    idle_id();
    id_valid = 1'b1; id_rs1 = 5'd3; id_rs1_use = 1'b1;
    #1;
    checks++; if (fwd_sel1 !== (FWD ? 2'd1 : 2'd0)) begin failures++; $display("FAIL young_fwd1 got=%0d exp=%0d", fwd_sel1, FWD ? 1 : 0); end
    checks++; if (busy_vec !== 32'h8) begin failures++; $display("FAIL young_busy got=%h exp=00000008", busy_vec); end
    id_rs1 = 5'd0;
    #1;
    checks++; if (id_stall !== 1'b0) begin failures++; $display("FAIL r0_stall got=%b exp=0", id_stall); end
    checks++; if (fwd_sel1 !== 2'd0) begin failures++; $display("FAIL r0_fwd1 got=%0d exp=0", fwd_sel1); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_issue(5'd11, 1'b1, 1'b0);
    tick();
    set_issue(5'd10, 1'b1, 1'b0); ex_to_mem_fire = 1'b1;
    tick();
    set_issue(5'd9, 1'b1, 1'b0); ex_to_mem_fire = 1'b1; mem_to_wb_fire = 1'b1;
    tick();
    checks++; if (busy_vec !== 32'h00000E00) begin failures++; $display("FAIL full_busy got=%h exp=00000e00", busy_vec); end
    set_issue(5'd12, 1'b1, 1'b0);
    ex_to_mem_fire = 1'b1; mem_to_wb_fire = 1'b1; wb_retire = 1'b1;
    tick();
    checks++; if (busy_vec !== 32'h00001600) begin failures++; $display("FAIL shift1_busy got=%h exp=00001600", busy_vec); end
    set_issue(5'd0, 1'b1, 1'b0);
    ex_to_mem_fire = 1'b1; mem_to_wb_fire = 1'b1; wb_retire = 1'b1;
    tick();
    checks++; if (busy_vec !== 32'h00001200) begin failures++; $display("FAIL shift2_busy got=%h exp=00001200", busy_vec); end
    checks++; if (scb_err !== 1'b0) begin failures++; $display("FAIL b2b_err got=%b exp=0", scb_err); end
    idle_id();
    id_valid = 1'b1; id_rs2 = 5'd12; id_rs2_use = 1'b1;
    #1;
    checks++; if (fwd_sel2 !== (FWD ? 2'd2 : 2'd0)) begin failures++; $display("FAIL b2b_fwd2 got=%0d exp=%0d", fwd_sel2, FWD ? 2 : 0); end
    checks++; if (id_stall !== !FWD) begin failures++; $display("FAIL b2b_stall got=%b exp=%b", id_stall, !FWD); end
  endtask

  task automatic test_errors();
    do_reset();
    wb_retire = 1'b1;
    tick();
    checks++; if (scb_err !== 1'b1) begin failures++; $display("FAIL err_retire got=%b exp=1", scb_err); end
    tick(); tick();
    checks++; if (scb_err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", scb_err); end
    do_reset();
    ex_to_mem_fire = 1'b1;
    tick();
    checks++; if (scb_err !== 1'b1) begin failures++; $display("FAIL err_ex_empty got=%b exp=1", scb_err); end
    do_reset();
    set_issue(5'd1, 1'b1, 1'b0);
    tick();
    ex_to_mem_fire = 1'b1;
    tick();
    mem_to_wb_fire = 1'b1;
    tick();
    set_issue(5'd2, 1'b1, 1'b0);
    tick();
    ex_to_mem_fire = 1'b1;
    tick();
    checks++; if (scb_err !== 1'b0) begin failures++; $display("FAIL err_none got=%b exp=0", scb_err); end
    mem_to_wb_fire = 1'b1;
    tick();
    checks++; if (scb_err !== 1'b1) begin failures++; $display("FAIL err_wb_overwrite got=%b exp=1", scb_err); end
    checks++; if (busy_vec !== 32'h4) begin failures++; $display("FAIL err_proceed_busy got=%h exp=00000004", busy_vec); end
    do_reset();
    set_issue(5'd5, 1'b1, 1'b0);
    tick();
    set_issue(5'd6, 1'b1, 1'b0);
    id_rs1 = 5'd5; id_rs1_use = 1'b1;
    tick();
    checks++; if (scb_err !== !FWD) begin failures++; $display("FAIL err_issue_stall got=%b exp=%b", scb_err, !FWD); end
    set_issue(5'd8, 1'b1, 1'b0); ex_to_mem_fire = 1'b1; mem_to_wb_fire = 1'b1;
    tick();
    idle_id();
    id_valid = 1'b1; id_rs1 = 5'd8; id_rs1_use = 1'b1; id_rs2 = 5'd6; id_rs2_use = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (busy_vec !== 32'h0) begin failures++; $display("FAIL midreset_busy got=%h exp=0", busy_vec); end
    checks++; if (id_stall !== 1'b0) begin failures++; $display("FAIL midreset_stall got=%b exp=0", id_stall); end
    checks++; if (fwd_sel1 !== 2'd0 || fwd_sel2 !== 2'd0) begin failures++; $display("FAIL midreset_fwd got=%0d/%0d exp=0/0", fwd_sel1, fwd_sel2); end
    checks++; if (scb_err !== 1'b0) begin failures++; $display("FAIL midreset_err got=%b exp=0", scb_err); end
  endtask

  initial begin
    reset = 1'b1;
    id_to_ex_fire = 1'b0; ex_to_mem_fire = 1'b0; mem_to_wb_fire = 1'b0; wb_retire = 1'b0;
    idle_id();
    test_reset();
    test_stall_pipeline();
    test_load_use();
    test_youngest();
    test_back_to_back();
    test_errors();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
